uart_rx_cfg: RTL and testbench

Parametrised, runtime-configurable UART receiver with 16x oversampling and majority-vote bit sampling. Supports 5–9 data bits, optional even/odd parity, 1 or 2 stop bits, glitch rejection, break detection and a valid/ready output with overrun reporting. It sits between the board-level `rx` pin and the byte-stream consumer (FIFO or command parser), superseding the fixed-format receiver.

---
 rtl/uart_rx_cfg.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 16x oversampling, 3-sample majority vote,
// 5..DATA_BITS data bits, optional parity, 1/2 stop bits, break and overrun flags.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [BAUD_W-1:0]    baud_div,
    input  logic [3:0]           char_len,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE
    } state_t;

    state_t state, state_nxt;

    logic                 rx_s1, rx_s2, rx_d;
    logic [BAUD_W-1:0]    baud_cnt, div_eff;
    logic [OS_W-1:0]      os_cnt;
    logic                 smp_a, smp_b;
    logic                 tick, decide, bit_end, vote, fall, start_det;
    logic [3:0]           len_clamp, len_q, bit_cnt;
    logic                 par_en_q, par_odd_q, stop2_q;
    logic [DATA_BITS-1:0] acc_data;
    logic                 par_acc, zero_acc, par_err_q;
    logic                 commit, ferr_now, brk_now;

    assign div_eff   = (baud_div == '0) ? BAUD_W'(1) : baud_div;
    assign fall      = rx_d & ~rx_s2;
    assign start_det = (state == IDLE) && fall;
    assign tick      = (state != IDLE) && (state != WAIT_IDLE)
                       && (baud_cnt == div_eff - BAUD_W'(1));
    assign decide    = tick && (os_cnt == OS_W'(OVERSAMPLE / 2 + 1));
    assign bit_end   = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
    // Third sample is taken live at the decision tick.
    assign vote      = (smp_a & smp_b) | (smp_a & rx_s2) | (smp_b & rx_s2);
    assign busy      = (state != IDLE);

    always_comb begin
        len_clamp = char_len;
        if (char_len < 4'd5)
            len_clamp = 4'd5;
        else if (char_len > 4'(DATA_BITS))
            len_clamp = 4'(DATA_BITS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
            state <= IDLE;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        ferr_now  = 1'b0;
        case (state)
            IDLE:      if (fall) state_nxt = START;
            START: begin
                if (decide && vote)
                    state_nxt = IDLE;
                else if (bit_end)
                    state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && (bit_cnt == len_q - 4'd1))
                    state_nxt = par_en_q ? PARITY : STOP1;
            end
            PARITY:    if (bit_end) state_nxt = STOP1;
            STOP1: begin
                if (decide && !vote) begin
                    commit    = 1'b1;
                    ferr_now  = 1'b1;
                    state_nxt = WAIT_IDLE;
                end else if (decide && !stop2_q) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    state_nxt = STOP2;
                end
            end
            STOP2: begin
                if (decide) begin
                    commit    = 1'b1;
                    ferr_now  = !vote;
                    state_nxt = vote ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: if (rx_s2) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // A break is only possible when the first stop bit itself was low.
    assign brk_now = ferr_now && (state == STOP1) && zero_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt  <= '0;
            os_cnt    <= '0;
            smp_a     <= 1'b1;
            smp_b     <= 1'b1;
            len_q     <= 4'd8;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            acc_data  <= '0;
            bit_cnt   <= '0;
            par_acc   <= 1'b0;
            zero_acc  <= 1'b1;
            par_err_q <= 1'b0;
        end else begin
            if (state == IDLE || state == WAIT_IDLE) begin
                baud_cnt <= '0;
                os_cnt   <= '0;
            end else if (tick) begin
                baud_cnt <= '0;
                os_cnt   <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + OS_W'(1);
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            if (tick && os_cnt == OS_W'(OVERSAMPLE / 2 - 1)) smp_a <= rx_s2;
            if (tick && os_cnt == OS_W'(OVERSAMPLE / 2))     smp_b <= rx_s2;

            if (start_det) begin
                len_q     <= len_clamp;
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                stop2_q   <= stop2;
                acc_data  <= '0;
                bit_cnt   <= '0;
                par_acc   <= 1'b0;
                zero_acc  <= 1'b1;
                par_err_q <= 1'b0;
            end

            if (decide && state == DATA) begin
                acc_data <= acc_data | (DATA_BITS'(vote) << bit_cnt);
                par_acc  <= par_acc ^ vote;
                if (vote) zero_acc <= 1'b0;
            end
            if (decide && state == PARITY) begin
                par_err_q <= vote ^ par_acc ^ par_odd_q;
                if (vote) zero_acc <= 1'b0;
            end
            if (bit_end && state == DATA) bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // Output holding register: m_valid/m_ready handshake, a commit while
    // held and not accepted is dropped and flagged as overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (commit) begin
            if (!m_valid || m_ready) begin
                m_data     <= acc_data;
                m_valid    <= 1'b1;
                frame_err  <= ferr_now;
                parity_err <= par_err_q;
                break_det  <= brk_now;
                overrun    <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are built bit by bit on rx and the
// held character/flags are compared with hand-computed values.
module tb_uart_rx_cfg;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [15:0] baud_div;
    logic [3:0]  char_len;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        frame_err;
    logic        parity_err;
    logic        break_det;
    logic        overrun;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int bit_clk  = 432;

    uart_rx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .BAUD_W(16)) dut (
        .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div), .char_len(char_len),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .frame_err(frame_err), .parity_err(parity_err), .break_det(break_det),
        .overrun(overrun), .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks (called at a falling clock edge)
    task automatic send_bit(input logic v);
        rx = v;
        repeat (bit_clk) @(negedge clk);
    endtask

    // par: 0 none, 1 even, 2 odd; flip inverts the parity bit
    task automatic send_data(input logic [8:0] data, input int n, input int par, input logic flip);
        logic p;
        p = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < n; i++) begin
            send_bit(data[i]);
            p = p ^ data[i];
        end
        if (par != 0) begin
            if (par == 2) p = ~p;
            if (flip) p = ~p;
            send_bit(p);
        end
    endtask

    task automatic send_frame(input logic [8:0] data, input int n, input int par,
                              input logic flip, input int nstop);
        send_data(data, n, par, flip);
        for (int i = 0; i < nstop; i++) send_bit(1'b1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 4 * bit_clk && !m_valid; i++) @(negedge clk);
        check(tag, m_valid, 1'b1);
    endtask

    task automatic accept();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic check_char(input string tag, input logic [7:0] d, input logic fe,
                              input logic pe, input logic br, input logic ov);
        wait_valid({tag, "_valid"});
        check({tag, "_data"}, m_data, d);
        check({tag, "_ferr"}, frame_err, fe);
        check({tag, "_perr"}, parity_err, pe);
        check({tag, "_brk"}, break_det, br);
        check({tag, "_ovr"}, overrun, ov);
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; m_ready = 1'b0; baud_div = 16'd27;
        char_len = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", m_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", m_data, 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 0x55 at baud_div=27; commit lands mid stop bit
        send_data(9'h055, 8, 0, 1'b0);
        rx = 1'b1;
        repeat (5 * 27) @(negedge clk);
        check("t1_early_valid", m_valid, 1'b0);
        repeat (7 * 27) @(negedge clk);
        check("t1_mid_stop_valid", m_valid, 1'b1);
        repeat (4 * 27) @(negedge clk);
        check_char("t1", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_busy", busy, 1'b0);
        accept();
        check("t1_accept_valid", m_valid, 1'b0);

        baud_div = 16'd4;
        bit_clk  = 64;

        // 8E1 0xA3 good and bad parity, then 7O2 0x41
        parity_en = 1'b1;
        send_frame(9'h0A3, 8, 1, 1'b0, 1);
        check_char("e1_good", 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();
        send_frame(9'h0A3, 8, 1, 1'b1, 1);
        check_char("e1_bad", 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
        accept();
        char_len = 4'd7; parity_odd = 1'b1; stop2 = 1'b1;
        send_frame(9'h041, 7, 2, 1'b0, 2);
        check_char("o2", 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();

        // bad stop bit, line held low three more bit times
        char_len = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
        send_data(9'h0F0, 8, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        check_char("fe", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("fe_busy_low", busy, 1'b1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("fe_busy_high", busy, 1'b0);
        accept();

        // break with 8E1
        parity_en = 1'b1;
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        check_char("brk", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("brk_busy", busy, 1'b0);
        accept();

        // glitch of 4 oversample ticks, then a clean frame
        parity_en = 1'b0;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        check("gl_busy", busy, 1'b0);
        check("gl_valid", m_valid, 1'b0);
        send_frame(9'h03C, 8, 0, 1'b0, 1);
        check_char("gl_next", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();

        // char_len clamping: 2 -> 5 bits, 15 -> 8 bits
        char_len = 4'd2;
        send_frame(9'h01B, 5, 0, 1'b0, 1);
        check_char("cl_low", 8'h1B, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();
        char_len = 4'd15;
        send_frame(9'h0C9, 8, 0, 1'b0, 1);
        check_char("cl_high", 8'hC9, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();
        char_len = 4'd8;

        // baud_div 0 behaves as 1
        baud_div = 16'd0;
        bit_clk  = 16;
        send_frame(9'h096, 8, 0, 1'b0, 1);
        check_char("div0", 8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
        accept();
        baud_div = 16'd4;
        bit_clk  = 64;

        // overrun: back-to-back frames, no accept
        send_frame(9'h011, 8, 0, 1'b0, 1);
        send_frame(9'h022, 8, 0, 1'b0, 1);
        check_char("ovr", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        accept();
        check("ovr_clr_valid", m_valid, 1'b0);
        check("ovr_clr_ovr", overrun, 1'b0);

        // reset mid-frame with a character still held
        send_frame(9'h05A, 8, 0, 1'b0, 1);
        check("rm_held", m_data, 8'h5A);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("rm_busy_before", busy, 1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rm_valid", m_valid, 1'b0);
        check("rm_data", m_data, 8'h00);
        check("rm_busy", busy, 1'b0);
        check("rm_ovr", overrun, 1'b0);
        repeat (12 * 64) @(negedge clk);
        check("rm_no_char", m_valid, 1'b0);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
